// File: rtl/trena_multimodo.sv
// Ultrasonic range finder: triggers the sensor, times the echo directly in BCD centimetres
// and streams the result as ASCII digits plus a terminator to a byte-oriented serial TX.
module trena_multimodo #(
    parameter int          DIGITOS        = 3,
    parameter int          TRIG_CICLOS    = 500,
    parameter int          CICLOS_POR_CM  = 2941,
    parameter int          TIMEOUT_CICLOS = 1500000,
    parameter int          PERIODO_CICLOS = 5000000,
    parameter logic [7:0]  TERMINADOR     = 8'h23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mensurar,
    input  logic                   modo_continuo,
    input  logic                   echo,
    input  logic                   tx_pronto,
    output logic                   trigger,
    output logic                   tx_partida,
    output logic [7:0]             tx_dado,
    output logic [4*DIGITOS-1:0]   medida,
    output logic                   pronto,
    output logic                   erro_timeout,
    output logic [3:0]             db_estado
);

    localparam int T_A   = (TRIG_CICLOS > TIMEOUT_CICLOS) ? TRIG_CICLOS : TIMEOUT_CICLOS;
    localparam int T_MAX = (T_A > PERIODO_CICLOS) ? T_A : PERIODO_CICLOS;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int CW    = $clog2(CICLOS_POR_CM + 1);
    localparam int IW    = $clog2(DIGITOS + 1);

    localparam logic [TW-1:0] TRIG_FIM = TW'(TRIG_CICLOS - 1);
    localparam logic [TW-1:0] TO_FIM   = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] PER_FIM  = TW'(PERIODO_CICLOS - 1);
    localparam logic [CW-1:0] CM_FIM   = CW'(CICLOS_POR_CM - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        TRIGGER     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARMAZENA    = 4'd5,
        ENVIA       = 4'd6,
        ESPERA_TX   = 4'd7,
        FINAL       = 4'd8,
        PERIODO     = 4'd9,
        ERRO        = 4'd15
    } estado_t;

    estado_t              estado, proximo;
    logic [TW-1:0]        timer;
    logic [CW-1:0]        sub;
    logic [4*DIGITOS-1:0] acc;
    logic [IW-1:0]        indice;
    logic                 fim;

    // Decimal increment; a carry out of the top digit means all nines, so hold the value.
    function automatic logic [4*DIGITOS-1:0] bcd_inc(input logic [4*DIGITOS-1:0] v);
        logic [4*DIGITOS-1:0] r;
        logic                 carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITOS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return carry ? v : r;
    endfunction

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:     if (mensurar) proximo = PREPARA;
            PREPARA:     proximo = TRIGGER;
            TRIGGER:     if (timer == TRIG_FIM) proximo = ESPERA_ECHO;
            ESPERA_ECHO: if (echo) proximo = MEDE;
                         else if (timer == TO_FIM) proximo = ERRO;
            MEDE:        if (!echo) proximo = ARMAZENA;
                         else if (timer == TO_FIM) proximo = ERRO;
            ARMAZENA:    proximo = ENVIA;
            ENVIA:       proximo = ESPERA_TX;
            ESPERA_TX:   if (tx_pronto) proximo = fim ? FINAL : ENVIA;
            FINAL:       proximo = modo_continuo ? PERIODO : INICIAL;
            PERIODO:     if (!modo_continuo) proximo = INICIAL;
                         else if (timer == PER_FIM) proximo = PREPARA;
            ERRO:        proximo = modo_continuo ? PERIODO : INICIAL;
            default:     proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= INICIAL;
            timer        <= '0;
            sub          <= '0;
            acc          <= '0;
            indice       <= '0;
            fim          <= 1'b0;
            trigger      <= 1'b0;
            tx_partida   <= 1'b0;
            tx_dado      <= 8'h00;
            medida       <= '0;
            pronto       <= 1'b0;
            erro_timeout <= 1'b0;
        end else begin
            estado <= proximo;

            // The cycle that detects echo already counts as one echo-high cycle.
            if (estado == ESPERA_ECHO && proximo == MEDE) timer <= TW'(1);
            else if (proximo != estado)                   timer <= '0;
            else                                          timer <= timer + 1'b1;

            if (estado == PREPARA) begin
                sub <= '0;
                acc <= '0;
            end else if (echo && (estado == ESPERA_ECHO || estado == MEDE)) begin
                if (sub == CM_FIM) begin
                    sub <= '0;
                    acc <= bcd_inc(acc);
                end else begin
                    sub <= sub + 1'b1;
                end
            end

            trigger    <= (proximo == TRIGGER);
            pronto     <= (proximo == FINAL);
            tx_partida <= (estado == ENVIA);
            if (estado == ENVIA)
                tx_dado <= fim ? TERMINADOR : 8'h30 + {4'h0, medida[4*indice +: 4]};
            if (proximo == ARMAZENA) medida <= acc;

            if (proximo == PREPARA)   erro_timeout <= 1'b0;
            else if (proximo == ERRO) erro_timeout <= 1'b1;

            if (estado == ARMAZENA) begin
                indice <= IW'(DIGITOS - 1);
                fim    <= 1'b0;
            end else if (estado == ESPERA_TX && tx_pronto && !fim) begin
                if (indice == '0) fim    <= 1'b1;
                else              indice <= indice - 1'b1;
            end
        end
    end

    assign db_estado = estado;

endmodule
